// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory: independent write/read FSMs over a byte-strobed word array.
// Define EI_AXI4_WRAP_BURST_EN to accept WRAP bursts; otherwise burst 2'b10 answers SLVERR.
module ei_axi4_slave_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * BYTES);
  localparam logic [2:0] SIZE_OK = 3'(OFFS);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef EI_AXI4_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic cmdErr(input logic [2:0] size, input logic [1:0] burst,
                                  input logic [7:0] len, input logic [ADDR_W-1:0] addr);
    logic wrapBad;
    wrapBad = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) ||
              (addr[OFFS-1:0] != '0);
    cmdErr = (size != SIZE_OK) || (burst == 2'b11) ||
             (burst == 2'b10 && (!WRAP_EN || wrapBad));
  endfunction

  function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] addr,
                                                 input logic [1:0] burst,
                                                 input logic [7:0] len);
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] mask;
    incr = addr + ADDR_W'(BYTES);
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << OFFS) - ADDR_W'(1);
    if (burst == 2'b00)
      nextAddr = addr;
    else if (WRAP_EN && burst == 2'b10)
      nextAddr = (addr & ~mask) | (incr & mask);
    else
      nextAddr = incr;
  endfunction

  wstate_e           wState_q, wState_d;
  logic [ID_W-1:0]   awId_q, awId_d;
  logic [ADDR_W-1:0] awAddr_q, awAddr_d;
  logic [7:0]        awLen_q, awLen_d, wBeat_q, wBeat_d;
  logic [2:0]        awSize_q, awSize_d;
  logic [1:0]        awBurst_q, awBurst_d;
  logic              wErr_q, wErr_d, awReady_q;
  logic              wLastBeat, wBeatErr, memWe;
  logic [IDXW-1:0]   wIdx;

  assign wLastBeat = (wBeat_q == awLen_q);
  assign wBeatErr  = cmdErr(awSize_q, awBurst_q, awLen_q, awAddr_q) ||
                     (awAddr_q >= LIMIT) || (wlast != wLastBeat);
  assign memWe     = (wState_q == W_DATA) && wvalid && !wBeatErr;
  assign wIdx      = awAddr_q[OFFS+IDXW-1:OFFS];

  always_comb begin
    wState_d  = wState_q;
    awId_d    = awId_q;
    awAddr_d  = awAddr_q;
    awLen_d   = awLen_q;
    awSize_d  = awSize_q;
    awBurst_d = awBurst_q;
    wBeat_d   = wBeat_q;
    wErr_d    = wErr_q;
    case (wState_q)
      W_IDLE: if (awvalid && awReady_q) begin
        awId_d    = awid;
        awAddr_d  = awaddr;
        awLen_d   = awlen;
        awSize_d  = awsize;
        awBurst_d = awburst;
        wBeat_d   = '0;
        wErr_d    = 1'b0;
        wState_d  = W_DATA;
      end
      W_DATA: if (wvalid) begin
        wErr_d   = wErr_q | wBeatErr;
        awAddr_d = nextAddr(awAddr_q, awBurst_q, awLen_q);
        wBeat_d  = wBeat_q + 8'd1;
        if (wLastBeat) wState_d = W_RESP;
      end
      W_RESP: if (bready) wState_d = W_IDLE;
      default: wState_d = W_IDLE;
    endcase
  end

  // awready is registered so it stays low for the whole reset and the first edge after it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wState_q  <= W_IDLE;
      awId_q    <= '0;
      awAddr_q  <= '0;
      awLen_q   <= '0;
      awSize_q  <= '0;
      awBurst_q <= '0;
      wBeat_q   <= '0;
      wErr_q    <= 1'b0;
      awReady_q <= 1'b0;
    end else begin
      wState_q  <= wState_d;
      awId_q    <= awId_d;
      awAddr_q  <= awAddr_d;
      awLen_q   <= awLen_d;
      awSize_q  <= awSize_d;
      awBurst_q <= awBurst_d;
      wBeat_q   <= wBeat_d;
      wErr_q    <= wErr_d;
      awReady_q <= (wState_d == W_IDLE);
    end
  end

  always_ff @(posedge aclk) begin
    if (memWe)
      for (int b = 0; b < BYTES; b++)
        if (wstrb[b]) mem[wIdx][8*b +: 8] <= wdata[8*b +: 8];
  end

  assign awready = awReady_q;
  assign wready  = (wState_q == W_DATA);
  assign bvalid  = (wState_q == W_RESP);
  assign bresp   = (bvalid && wErr_q) ? RESP_SLVERR : RESP_OKAY;
  assign bid     = awId_q;

  rstate_e           rState_q, rState_d;
  logic [ID_W-1:0]   arId_q, arId_d;
  logic [ADDR_W-1:0] arAddr_q, arAddr_d, rLoadAddr;
  logic [7:0]        arLen_q, arLen_d, rBeat_q, rBeat_d;
  logic [2:0]        arSize_q, arSize_d;
  logic [1:0]        arBurst_q, arBurst_d, rResp_q, rResp_d;
  logic [DATA_W-1:0] rData_q, rData_d, rWord;
  logic              arReady_q, rLoad, rLoadCmdErr, rLoadErr;
  logic [IDXW-1:0]   rIdx;

  always_comb begin
    rState_d    = rState_q;
    arId_d      = arId_q;
    arAddr_d    = arAddr_q;
    arLen_d     = arLen_q;
    arSize_d    = arSize_q;
    arBurst_d   = arBurst_q;
    rBeat_d     = rBeat_q;
    rLoad       = 1'b0;
    rLoadAddr   = arAddr_q;
    rLoadCmdErr = 1'b0;
    case (rState_q)
      R_IDLE: if (arvalid && arReady_q) begin
        arId_d      = arid;
        arAddr_d    = araddr;
        arLen_d     = arlen;
        arSize_d    = arsize;
        arBurst_d   = arburst;
        rBeat_d     = '0;
        rLoad       = 1'b1;
        rLoadAddr   = araddr;
        rLoadCmdErr = cmdErr(arsize, arburst, arlen, araddr);
        rState_d    = R_DATA;
      end
      R_DATA: if (rready) begin
        if (rBeat_q == arLen_q) begin
          rState_d = R_IDLE;
        end else begin
          rBeat_d     = rBeat_q + 8'd1;
          arAddr_d    = nextAddr(arAddr_q, arBurst_q, arLen_q);
          rLoad       = 1'b1;
          rLoadAddr   = arAddr_d;
          rLoadCmdErr = cmdErr(arSize_q, arBurst_q, arLen_q, arAddr_q);
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  // Forward a write committing on this same edge so the next presented beat sees it.
  assign rIdx = rLoadAddr[OFFS+IDXW-1:OFFS];
  always_comb begin
    rWord = mem[rIdx];
    if (memWe && wIdx == rIdx)
      for (int b = 0; b < BYTES; b++)
        if (wstrb[b]) rWord[8*b +: 8] = wdata[8*b +: 8];
  end

  assign rLoadErr = rLoadCmdErr || (rLoadAddr >= LIMIT);
  assign rData_d  = !rLoad ? rData_q : (rLoadErr ? '0 : rWord);
  assign rResp_d  = !rLoad ? rResp_q : (rLoadErr ? RESP_SLVERR : RESP_OKAY);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rState_q  <= R_IDLE;
      arId_q    <= '0;
      arAddr_q  <= '0;
      arLen_q   <= '0;
      arSize_q  <= '0;
      arBurst_q <= '0;
      rBeat_q   <= '0;
      rData_q   <= '0;
      rResp_q   <= '0;
      arReady_q <= 1'b0;
    end else begin
      rState_q  <= rState_d;
      arId_q    <= arId_d;
      arAddr_q  <= arAddr_d;
      arLen_q   <= arLen_d;
      arSize_q  <= arSize_d;
      arBurst_q <= arBurst_d;
      rBeat_q   <= rBeat_d;
      rData_q   <= rData_d;
      rResp_q   <= rResp_d;
      arReady_q <= (rState_d == R_IDLE);
    end
  end

  assign arready = arReady_q;
  assign rvalid  = (rState_q == R_DATA);
  assign rlast   = rvalid && (rBeat_q == arLen_q);
  assign rdata   = rData_q;
  assign rresp   = rResp_q;
  assign rid     = arId_q;

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Self-checking bench for ei_axi4_slave_mem: directed vector table, corner sequences,
// and random bursts checked against a byte-level memory model.
module tb_ei_axi4_slave_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int DEPTH  = 1024;
  localparam int TIMEOUT = 200;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

`ifdef EI_AXI4_WRAP_BURST_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  logic              aclk, aresetn;
  logic [ID_W-1:0]   awid, arid, bid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic [1:0]        awburst, arburst, bresp, rresp;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0]        wstrb;

  ei_axi4_slave_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    bit          isWrite;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] data;
    int          wlastBeat;
    bit          gaps;
    logic [1:0]  expResp;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [31:0] refMem [DEPTH];
  logic [3:0]  refKnown [DEPTH];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, logic [3:0] id, logic [31:0] addr, logic [7:0] len,
                              logic [2:0] size, logic [1:0] burst, logic [3:0] strb,
                              logic [31:0] data, int wl, logic [1:0] er);
    vec_t v;
    v.isWrite = w; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.strb = strb; v.data = data; v.wlastBeat = wl; v.gaps = 1'b0; v.expResp = er;
    return v;
  endfunction

  // Reference address of beat n, straight from the burst arithmetic.
  function automatic logic [31:0] beatAddr(input vec_t v, input int n);
    longint span, lower;
    if (v.burst == 2'b00) return v.addr;
    if (v.burst == 2'b10 && WRAP_ON) begin
      span  = (longint'(v.len) + 1) * 4;
      lower = (longint'(v.addr) / span) * span;
      return 32'(lower + ((longint'(v.addr) - lower + longint'(n) * 4) % span));
    end
    return v.addr + 32'(n * 4);
  endfunction

  function automatic bit burstErr(input vec_t v);
    if (v.size != 3'd2) return 1'b1;
    if (v.burst == 2'b11) return 1'b1;
    if (v.burst == 2'b10) begin
      if (!WRAP_ON) return 1'b1;
      if (!(v.len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 1'b1;
      if (v.addr % 4 != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic writeBurst(input vec_t v, output logic [1:0] resp);
    int n;
    logic [31:0] a;
    bit anyBad, beatBad;
    resp = 2'b11;
    @(negedge aclk);
    awvalid = 1'b1; awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
    n = 0;
    while (!awready && n < TIMEOUT) begin @(negedge aclk); n++; end
    if (!awready) begin checkOutput("aw_timeout", 0, 1); awvalid = 1'b0; return; end
    @(negedge aclk);
    awvalid = 1'b0;
    checkOutput("wready_latency", wready, 1);
    anyBad = burstErr(v);
    for (int i = 0; i <= int'(v.len); i++) begin
      if (v.gaps) while ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge aclk); end
      wvalid = 1'b1;
      wdata  = v.data + 32'(i);
      wstrb  = v.strb;
      wlast  = (v.wlastBeat < 0) ? (i == int'(v.len)) : (i == v.wlastBeat);
      n = 0;
      while (!wready && n < TIMEOUT) begin @(negedge aclk); n++; end
      if (!wready) begin checkOutput("w_timeout", 0, 1); wvalid = 1'b0; return; end
      @(negedge aclk);
      a = beatAddr(v, i);
      beatBad = burstErr(v) || (a >= 32'(DEPTH * 4)) || (wlast != (i == int'(v.len)));
      if (beatBad) anyBad = 1'b1;
      else
        for (int b = 0; b < 4; b++)
          if (v.strb[b]) begin
            refMem[a[11:2]][8*b +: 8] = wdata[8*b +: 8];
            refKnown[a[11:2]][b] = 1'b1;
          end
    end
    wvalid = 1'b0; wlast = 1'b0;
    checkOutput("bvalid_latency", bvalid, 1);
    if (v.gaps) repeat ($urandom_range(0, 2)) @(negedge aclk);
    checkOutput("bresp_model", bresp, anyBad ? SLVERR : OKAY);
    checkOutput("bid", bid, v.id);
    resp = bresp;
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  // rrMode: 0 always ready, 1 random, 2 fixed pattern 1,0,0,1,1,1 then 1.
  task automatic readBurst(input vec_t v, input int rrMode, output logic [1:0] respOr,
                           output logic [31:0] firstData, output int beats);
    int n, cyc;
    logic [31:0] a, expData, mask;
    bit beatBad;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    respOr = OKAY; firstData = '0; beats = 0;
    @(negedge aclk);
    arvalid = 1'b1; arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
    n = 0;
    while (!arready && n < TIMEOUT) begin @(negedge aclk); n++; end
    if (!arready) begin checkOutput("ar_timeout", 0, 1); arvalid = 1'b0; return; end
    @(negedge aclk);
    arvalid = 1'b0;
    checkOutput("rvalid_latency", rvalid, 1);
    cyc = 0;
    while (beats <= int'(v.len) && cyc < TIMEOUT) begin
      case (rrMode)
        0: rready = 1'b1;
        1: rready = ($urandom_range(0, 2) != 0);
        default: rready = (cyc < 6) ? pat[cyc] : 1'b1;
      endcase
      if (rvalid) begin
        a = beatAddr(v, beats);
        beatBad = burstErr(v) || (a >= 32'(DEPTH * 4));
        expData = beatBad ? 32'h0 : refMem[a[11:2]];
        mask = 32'hFFFF_FFFF;
        if (!beatBad)
          for (int b = 0; b < 4; b++) mask[8*b +: 8] = refKnown[a[11:2]][b] ? 8'hFF : 8'h00;
        checkOutput("rresp", rresp, beatBad ? SLVERR : OKAY);
        checkOutput("rdata", rdata & mask, expData & mask);
        checkOutput("rlast", rlast, beats == int'(v.len));
        checkOutput("rid", rid, v.id);
        if (rready) begin
          respOr |= rresp;
          if (beats == 0) firstData = rdata;
          beats++;
        end
      end
      @(negedge aclk);
      cyc++;
    end
    rready = 1'b0;
    checkOutput("beat_count", beats, int'(v.len) + 1);
    checkOutput("rvalid_after_last", rvalid, 0);
  endtask

  task automatic applyStimulus(input vec_t v, input int rrMode, output logic [1:0] resp,
                               output logic [31:0] firstData, output int beats);
    firstData = '0; beats = 0;
    if (v.isWrite) writeBurst(v, resp);
    else readBurst(v, rrMode, resp, firstData, beats);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[16];
    vec_t v;
    logic [1:0] resp;
    logic [31:0] first;
    int beats;

    vecs[0]  = mk(1, 4'h1, 32'h000, 8'd127, 3'd2, 2'b01, 4'hF, 32'h1000_0000, -1, OKAY);
    vecs[1]  = mk(1, 4'h3, 32'h100, 8'd3,   3'd2, 2'b01, 4'hF, 32'h0000_00A0, -1, OKAY);
    vecs[2]  = mk(0, 4'h5, 32'h100, 8'd3,   3'd2, 2'b01, 4'hF, 32'h0,         -1, OKAY);
    vecs[3]  = mk(1, 4'h2, 32'h000, 8'd0,   3'd2, 2'b01, 4'hF, 32'hFFFF_FFFF, -1, OKAY);
    vecs[4]  = mk(1, 4'h2, 32'h000, 8'd0,   3'd2, 2'b01, 4'h5, 32'h1234_5678, -1, OKAY);
    vecs[5]  = mk(0, 4'h6, 32'h000, 8'd0,   3'd2, 2'b01, 4'hF, 32'h0,         -1, OKAY);
    vecs[6]  = mk(1, 4'h7, 32'h1000, 8'd0,  3'd2, 2'b01, 4'hF, 32'hDEAD_0000, -1, SLVERR);
    vecs[7]  = mk(1, 4'h8, 32'h020, 8'd3,   3'd2, 2'b01, 4'hF, 32'h0000_0055,  1, SLVERR);
    vecs[8]  = mk(0, 4'h9, 32'h000, 8'd0,   3'd1, 2'b01, 4'hF, 32'h0,         -1, SLVERR);
    vecs[9]  = mk(1, 4'hA, 32'h040, 8'd2,   3'd2, 2'b00, 4'hF, 32'h0000_0077, -1, OKAY);
    vecs[10] = mk(0, 4'hB, 32'h040, 8'd1,   3'd2, 2'b00, 4'hF, 32'h0,         -1, OKAY);
    vecs[11] = mk(1, 4'hC, 32'h050, 8'd1,   3'd2, 2'b11, 4'hF, 32'h0000_0011, -1, SLVERR);
    vecs[12] = mk(1, 4'hD, 32'h108, 8'd3,   3'd2, 2'b10, 4'hF, 32'h0000_00B0, -1, WRAP_ON ? OKAY : SLVERR);
    vecs[13] = mk(0, 4'hE, 32'h108, 8'd3,   3'd2, 2'b10, 4'hF, 32'h0,         -1, WRAP_ON ? OKAY : SLVERR);
    vecs[14] = mk(0, 4'hF, 32'hFF8, 8'd3,   3'd2, 2'b01, 4'hF, 32'h0,         -1, SLVERR);
    vecs[15] = mk(0, 4'h4, 32'h000, 8'd0,   3'd2, 2'b01, 4'hF, 32'h0,         -1, OKAY);

    for (int i = 0; i < DEPTH; i++) begin refMem[i] = '0; refKnown[i] = '0; end
    aresetn = 1'b0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;

    repeat (3) @(negedge aclk);
    checkOutput("rst_awready", awready, 0);
    checkOutput("rst_arready", arready, 0);
    checkOutput("rst_wready", wready, 0);
    checkOutput("rst_bvalid", bvalid, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_rlast", rlast, 0);
    checkOutput("rst_bresp", bresp, 0);
    checkOutput("rst_rresp", rresp, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_ids", {bid, rid}, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("post_rst_awready", awready, 1);
    checkOutput("post_rst_arready", arready, 1);
    checkOutput("post_rst_quiet", {wready, bvalid, rvalid, rlast}, 0);

    $display("[TB] directed vectors");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i], 0, resp, first, beats);
      checkOutput($sformatf("vec%0d_resp", i), resp, vecs[i].expResp);
      if (i == 2)  checkOutput("incr_first_data", first, 32'h0000_00A0);
      if (i == 5)  checkOutput("strobe_merge", first, 32'hFF34_FF78);
      if (i == 13) checkOutput("wrap_first_data", first, WRAP_ON ? 32'h0000_00B0 : 32'h0);
      if (i == 15) checkOutput("oob_write_no_effect", first, 32'hFF34_FF78);
    end

    $display("[TB] back-pressure read");
    v = mk(0, 4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 4'hF, 32'h0, -1, OKAY);
    applyStimulus(v, 2, resp, first, beats);
    checkOutput("bp_beats", beats, 4);

    $display("[TB] reset mid-burst");
    @(negedge aclk);
    awvalid = 1'b1; awid = 4'h9; awaddr = 32'h200; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01;
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1'b1; wdata = 32'hC0 + 32'(i); wstrb = 4'hF; wlast = 1'b0;
      @(negedge aclk);
      refMem[128 + i] = 32'hC0 + 32'(i);
      refKnown[128 + i] = 4'hF;
    end
    wvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    checkOutput("midrst_wready", wready, 0);
    checkOutput("midrst_ready", {awready, arready}, 0);
    checkOutput("midrst_valids", {bvalid, rvalid}, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("midrst_awready_back", awready, 1);
    v = mk(0, 4'h3, 32'h200, 8'd1, 3'd2, 2'b01, 4'hF, 32'h0, -1, OKAY);
    applyStimulus(v, 0, resp, first, beats);
    checkOutput("midrst_committed", first, 32'h0000_00C0);

    $display("[TB] random bursts");
    for (int t = 0; t < 40; t++) begin
      v.isWrite = ($urandom_range(0, 1) == 1);
      v.id      = 4'($urandom);
      v.addr    = 32'($urandom_range(0, 127)) * 4;
      if ($urandom_range(0, 9) == 0) v.addr = 32'h1000 - 32'($urandom_range(1, 4)) * 4;
      v.len     = 8'($urandom_range(0, 7));
      v.size    = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
      v.burst   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      v.strb    = 4'($urandom);
      v.data    = $urandom;
      v.wlastBeat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      v.gaps    = 1'b1;
      v.expResp = OKAY;
      applyStimulus(v, 1, resp, first, beats);
    end

    repeat (2) @(negedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
